// File: rtl/pipe_ex.sv
// Execute stage: ID/EX register, 32-bit ALU and optional iterative multiplier.
// Define EX_MUL_EN to build the multiplier FSM; without it aluc=1010 is an unused code.
module pipe_ex (
    input  logic        clk,
    input  logic        clrn,
    input  logic        IDwreg,
    input  logic        IDm2reg,
    input  logic        IDwmem,
    input  logic [4:0]  IDwn,
    input  logic [3:0]  IDaluc,
    input  logic        IDaluimm,
    input  logic        IDshift,
    input  logic [31:0] IDqa,
    input  logic [31:0] IDqb,
    input  logic [31:0] IDimm,
    output logic        EXwreg,
    output logic        EXm2reg,
    output logic        EXwmem,
    output logic [4:0]  EXwn,
    output logic [31:0] EXaluResult,
    output logic [31:0] EXdi,
    output logic        EXbusy,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0001;
    localparam logic [3:0] ALUC_AND = 4'b0010;
    localparam logic [3:0] ALUC_OR  = 4'b0011;
    localparam logic [3:0] ALUC_XOR = 4'b0100;
    localparam logic [3:0] ALUC_LUI = 4'b0101;
    localparam logic [3:0] ALUC_SLL = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1000;
    localparam logic [3:0] ALUC_SLT = 4'b1001;
    localparam logic [3:0] ALUC_MUL = 4'b1010;

    // ID/EX pipeline register
    logic        wreg_r;
    logic        m2reg_r;
    logic        wmem_r;
    logic [4:0]  wn_r;
    logic [3:0]  aluc_r;
    logic        aluimm_r;
    logic        shift_r;
    logic [31:0] qa_r;
    logic [31:0] qb_r;
    logic [31:0] imm_r;

    logic        busy;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_y;
    logic [31:0] result;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wreg_r   <= 1'b0;
            m2reg_r  <= 1'b0;
            wmem_r   <= 1'b0;
            wn_r     <= 5'd0;
            aluc_r   <= 4'd0;
            aluimm_r <= 1'b0;
            shift_r  <= 1'b0;
            qa_r     <= 32'd0;
            qb_r     <= 32'd0;
            imm_r    <= 32'd0;
        end else if (!busy) begin
            wreg_r   <= IDwreg;
            m2reg_r  <= IDm2reg;
            wmem_r   <= IDwmem;
            wn_r     <= IDwn;
            aluc_r   <= IDaluc;
            aluimm_r <= IDaluimm;
            shift_r  <= IDshift;
            qa_r     <= IDqa;
            qb_r     <= IDqb;
            imm_r    <= IDimm;
        end
    end

    assign op_a = shift_r  ? {27'd0, imm_r[10:6]} : qa_r;
    assign op_b = aluimm_r ? imm_r : qb_r;

    always_comb begin
        alu_y = 32'd0;
        case (aluc_r)
            ALUC_ADD: alu_y = op_a + op_b;
            ALUC_SUB: alu_y = op_a - op_b;
            ALUC_AND: alu_y = op_a & op_b;
            ALUC_OR:  alu_y = op_a | op_b;
            ALUC_XOR: alu_y = op_a ^ op_b;
            ALUC_LUI: alu_y = {op_b[15:0], 16'd0};
            ALUC_SLL: alu_y = op_b << op_a[4:0];
            ALUC_SRL: alu_y = op_b >> op_a[4:0];
            ALUC_SRA: alu_y = $signed(op_b) >>> op_a[4:0];
            ALUC_SLT: alu_y = {31'd0, ($signed(op_a) < $signed(op_b))};
            default:  alu_y = 32'd0;
        endcase
    end

`ifdef EX_MUL_EN
    parameter int MUL_CYCLES = 32;
    localparam int CNT_W = $clog2(MUL_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [31:0]       acc;
    logic [31:0]       mcand;
    logic [31:0]       mplier;
    logic [CNT_W-1:0]  cnt;
    logic              is_mul;

    assign is_mul = (aluc_r == ALUC_MUL);

    // Shift-add multiply; only the low 32 product bits are kept, so mcand wraps.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= S_IDLE;
            acc    <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        acc    <= 32'd0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // DONE is the one cycle the product is valid and the stage can accept again.
    assign busy      = is_mul && (state != S_DONE);
    assign result    = is_mul ? acc : alu_y;
    assign dbg_state = state;
`else
    assign busy      = 1'b0;
    assign result    = alu_y;
    assign dbg_state = 2'd0;
`endif

    // Bubble: hide control bits from MEM while the multiply is still running.
    assign EXwreg      = wreg_r  & ~busy;
    assign EXm2reg     = m2reg_r & ~busy;
    assign EXwmem      = wmem_r  & ~busy;
    assign EXwn        = wn_r;
    assign EXaluResult = result;
    assign EXdi        = qb_r;
    assign EXbusy      = busy;

endmodule

// File: tb/tb_pipe_ex.sv
// Self-checking bench for pipe_ex: directed scenarios plus randomized ALU traffic
// compared against an arithmetic reference model.
module tb_pipe_ex;

    localparam int W = 72;

    logic        clk;
    logic        clrn;
    logic        IDwreg;
    logic        IDm2reg;
    logic        IDwmem;
    logic [4:0]  IDwn;
    logic [3:0]  IDaluc;
    logic        IDaluimm;
    logic        IDshift;
    logic [31:0] IDqa;
    logic [31:0] IDqb;
    logic [31:0] IDimm;
    logic        EXwreg;
    logic        EXm2reg;
    logic        EXwmem;
    logic [4:0]  EXwn;
    logic [31:0] EXaluResult;
    logic [31:0] EXdi;
    logic        EXbusy;
    logic [1:0]  dbg_state;

    int n_cmp;
    int n_err;
    logic [W-1:0] exp_q[$];

    pipe_ex dut (
        .clk         (clk),
        .clrn        (clrn),
        .IDwreg      (IDwreg),
        .IDm2reg     (IDm2reg),
        .IDwmem      (IDwmem),
        .IDwn        (IDwn),
        .IDaluc      (IDaluc),
        .IDaluimm    (IDaluimm),
        .IDshift     (IDshift),
        .IDqa        (IDqa),
        .IDqb        (IDqb),
        .IDimm       (IDimm),
        .EXwreg      (EXwreg),
        .EXm2reg     (EXm2reg),
        .EXwmem      (EXwmem),
        .EXwn        (EXwn),
        .EXaluResult (EXaluResult),
        .EXdi        (EXdi),
        .EXbusy      (EXbusy),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        clrn = 1'b1;
        #2 clrn = 1'b0;
    end

    // reference model: operand rules and op table expressed as plain arithmetic
    function automatic logic [31:0] model_result(input logic [3:0] aluc, input logic [31:0] qa,
                                                 input logic [31:0] qb, input logic [31:0] imm,
                                                 input logic aluimm, input logic shift);
        logic [31:0] a;
        logic [31:0] b;
        int unsigned s;
        longint sa;
        longint sb;
        a  = shift ? ((imm / 64) % 32) : qa;
        b  = aluimm ? imm : qb;
        s  = a % 32;
        sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (aluc)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return b * 32'd65536;
            4'd6:  return b * (32'd1 << s);
            4'd7:  return b / (32'd1 << s);
            4'd8:  return 32'((sb - ((sb % (64'sd1 << s) + (64'sd1 << s)) % (64'sd1 << s))) / (64'sd1 << s));
            4'd9:  return (sa < sb) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
            4'd10: return 32'(longint'(a) * longint'(b));
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [W-1:0] model_bundle(input logic wreg, input logic m2reg, input logic wmem,
                                                  input logic [4:0] wn, input logic [31:0] res,
                                                  input logic [31:0] di);
        return {wreg, m2reg, wmem, wn, res, di};
    endfunction

    function automatic logic [W-1:0] dut_bundle();
        return {EXwreg, EXm2reg, EXwmem, EXwn, EXaluResult, EXdi};
    endfunction

    // driver tasks
    task automatic drive(input logic wreg, input logic m2reg, input logic wmem, input logic [4:0] wn,
                         input logic [3:0] aluc, input logic aluimm, input logic shift,
                         input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm);
        IDwreg   = wreg;
        IDm2reg  = m2reg;
        IDwmem   = wmem;
        IDwn     = wn;
        IDaluc   = aluc;
        IDaluimm = aluimm;
        IDshift  = shift;
        IDqa     = qa;
        IDqb     = qb;
        IDimm    = imm;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef EX_MUL_EN
    // Issues a MUL and follows it until EXbusy drops (bounded), randomizing ID inputs during the stall.
    task automatic run_mul(input logic [31:0] qa, input logic [31:0] qb, input logic [4:0] wn,
                           output int nbusy, output int nbubble_bad);
        drive(1'b1, 1'b0, 1'b0, wn, 4'd10, 1'b0, 1'b0, qa, qb, 32'd0);
        step();
        nbusy       = 0;
        nbubble_bad = 0;
        for (int i = 0; i < 40 && EXbusy; i++) begin
            nbusy++;
            if (EXwreg || EXm2reg || EXwmem) nbubble_bad++;
            drive_random();
            step();
        end
    endtask
`endif

    task automatic test_reset();
        logic [W-1:0] exp;
        drive(1'b1, 1'b1, 1'b1, 5'd31, 4'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF);
        #3;
        n_cmp++;
        if (dut_bundle() !== '0 || EXbusy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: got %h busy %b, want 0 busy 0", dut_bundle(), EXbusy);
        end
        @(negedge clk);
        clrn = 1'b1;
        step();
        // instruction is now in EX; yank reset mid-cycle
        #2 clrn = 1'b0;
        #1;
        n_cmp++;
        if (dut_bundle() !== '0 || EXbusy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got %h busy %b, want 0 busy 0", dut_bundle(), EXbusy);
        end
        #1 clrn = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd9, 4'd0, 1'b0, 1'b0, 32'd40, 32'd2, 32'd0);
        step();
        exp = model_bundle(1'b1, 1'b0, 1'b0, 5'd9, 32'd42, 32'd2);
        n_cmp++;
        if (dut_bundle() !== exp) begin
            n_err++;
            $display("FAIL reset_first_instr: got %h want %h", dut_bundle(), exp);
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  aluc_t[4]  = '{4'd0, 4'd1, 4'd9, 4'd8};
        logic        shift_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] qb_t[4]    = '{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h8000_0000};
        logic [31:0] imm_t[4]   = '{32'd0, 32'd0, 32'd0, 32'h0000_0100};
        logic [31:0] want_t[4]  = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'h0000_0001, 32'hF800_0000};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd3, aluc_t[i], 1'b0, shift_t[i], 32'hFFFF_0000, qb_t[i], imm_t[i]);
            step();
            n_cmp++;
            if (EXaluResult !== want_t[i] || EXwreg !== 1'b1 || EXbusy !== 1'b0) begin
                n_err++;
                $display("FAIL alu_sweep op%0d: got %h wreg %b busy %b, want %h wreg 1 busy 0",
                         aluc_t[i], EXaluResult, EXwreg, EXbusy, want_t[i]);
            end
        end
    endtask

    task automatic test_store();
        drive(1'b0, 1'b0, 1'b1, 5'd0, 4'd0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h4);
        step();
        n_cmp++;
        if (EXaluResult !== 32'h104 || EXdi !== 32'hDEAD_BEEF || EXwmem !== 1'b1 || EXwreg !== 1'b0) begin
            n_err++;
            $display("FAIL store: got addr %h di %h wmem %b wreg %b, want 104 deadbeef 1 0",
                     EXaluResult, EXdi, EXwmem, EXwreg);
        end
    endtask

    task automatic test_random_alu();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] aluc;
            aluc = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
            if (aluc == 4'd10) aluc = 4'd6;
`endif
            drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), aluc,
                  1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
            exp_q.push_back(model_bundle(IDwreg, IDm2reg, IDwmem, IDwn,
                                         model_result(IDaluc, IDqa, IDqb, IDimm, IDaluimm, IDshift), IDqb));
            step();
            got = dut_bundle();
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp || EXbusy !== 1'b0) begin
                n_err++;
                $display("FAIL random_alu[%0d] aluc %0d: got %h busy %b, want %h busy 0",
                         i, aluc, got, EXbusy, exp);
            end
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        int nbusy;
        int nbad;
        run_mul(32'd7, 32'hFFFF_FFFF, 5'd5, nbusy, nbad);
        n_cmp++;
        if (nbusy !== 33 || nbad !== 0) begin
            n_err++;
            $display("FAIL mul_stall: busy cycles %0d bubble leaks %0d, want 33 and 0", nbusy, nbad);
        end
        n_cmp++;
        if (EXaluResult !== model_result(4'd10, 32'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0)
            || EXwreg !== 1'b1 || EXwn !== 5'd5 || EXbusy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_result: got %h wreg %b wn %0d busy %b, want fffffff9 1 5 0",
                     EXaluResult, EXwreg, EXwn, EXbusy);
        end
    endtask

    task automatic test_back_to_back();
        int nbusy;
        int nbad;
        logic [31:0] a_t[3] = '{32'd3, 32'd0, 32'd0};
        logic [31:0] b_t[3] = '{32'd5, 32'd9, 32'd0};
        a_t[2] = $urandom;
        b_t[2] = $urandom;
        for (int i = 0; i < 3; i++) begin
            // each MUL is driven while the previous one sits in DONE
            run_mul(a_t[i], b_t[i], 5'(i + 1), nbusy, nbad);
            n_cmp++;
            if (nbusy !== 33 || nbad !== 0
                || EXaluResult !== model_result(4'd10, a_t[i], b_t[i], 32'd0, 1'b0, 1'b0)
                || EXwreg !== 1'b1) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: busy %0d leaks %0d result %h wreg %b, want 33 0 %h 1",
                         i, nbusy, nbad, EXaluResult, EXwreg,
                         model_result(4'd10, a_t[i], b_t[i], 32'd0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, 1'b0, 1'b0, 5'd4, 4'd10, 1'b0, 1'b0, 32'd11, 32'd13, 32'd0);
        step();
        for (int i = 0; i < 10; i++) step();
        n_cmp++;
        if (EXbusy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_mul_busy: got %b want 1", EXbusy);
        end
        #2 clrn = 1'b0;
        #1;
        n_cmp++;
        if (EXbusy !== 1'b0 || dut_bundle() !== '0) begin
            n_err++;
            $display("FAIL mid_mul_reset: busy %b bundle %h, want 0 and 0", EXbusy, dut_bundle());
        end
        #1 clrn = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd6, 4'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0);
        step();
        n_cmp++;
        if (EXaluResult !== 32'd5 || EXwreg !== 1'b1 || EXbusy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_add: got %h wreg %b busy %b, want 5 1 0", EXaluResult, EXwreg, EXbusy);
        end
    endtask
`else
    task automatic test_mul_disabled();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 4'd10, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFF, 32'd0);
        step();
        n_cmp++;
        if (EXaluResult !== 32'd0 || EXwreg !== 1'b1 || EXm2reg !== 1'b1 || EXwn !== 5'd5 || EXbusy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_disabled: got %h wreg %b m2reg %b wn %0d busy %b, want 0 1 1 5 0",
                     EXaluResult, EXwreg, EXm2reg, EXwn, EXbusy);
        end
        drive(1'b1, 1'b0, 1'b0, 5'd6, 4'd0, 1'b0, 1'b0, 32'd2, 32'd3, 32'd0);
        step();
        n_cmp++;
        if (EXaluResult !== 32'd5 || EXbusy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_disabled_next: got %h busy %b, want 5 0", EXaluResult, EXbusy);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_alu_sweep();
        test_store();
        test_random_alu();
`ifdef EX_MUL_EN
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_random_alu();
`else
        test_mul_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
